// File: rtl/maze_pkg.sv
// maze_pkg
//   Shared constants for the maze game blocks: default level-counter
//   geometry and the encodings used to pick the overflow behaviour and the
//   step trigger of level_counter.
package maze_pkg;

  // Default counter geometry: eight maze levels, 0..7.
  localparam int DEFAULT_WIDTH     = 3;
  localparam int DEFAULT_MAX_LEVEL = 7;

  // Overflow modes: wrap to the opposite end, or stick at the end.
  localparam int SAT_MODE  = 0;
  localparam int WRAP_MODE = 1;

  // Step trigger: every high cycle, or only on the rising edge.
  localparam int LEVEL_TRIGGER = 0;
  localparam int EDGE_TRIGGER  = 1;

endpackage

// File: rtl/level_counter_if.sv
// level_counter_if
//   Bundles the request and status signals between the game FSM (master)
//   and the level counter (slave).
//   master: drives clear, increment, decrement, load, load_value;
//           observes count, at_max, at_min, wrapped.
//   slave : the opposite directions.
interface level_counter_if
  import maze_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             clear;
  logic             increment;
  logic             decrement;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrapped;

  modport master (
    output clear, increment, decrement, load, load_value,
    input  count, at_max, at_min, wrapped
  );

  modport slave (
    input  clear, increment, decrement, load, load_value,
    output count, at_max, at_min, wrapped
  );

endinterface

// File: rtl/rise_detect.sv
// rise_detect
//   Single-input rising-edge detector.
//   clk    : system clock
//   reset  : synchronous active-high reset, clears the history bit
//   sig_in : level input to watch
//   rise   : high in the cycle where sig_in is high and was low last cycle
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sig_prev;

  // History bit samples every cycle; clearing it in reset means an input
  // already held high when reset releases still produces one rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_prev <= 1'b0;
    end else begin
      sig_prev <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_prev;

endmodule

// File: rtl/level_counter.sv
// level_counter
//   Current maze level with up/down stepping, load, clear and selectable
//   wrap/saturate behaviour at both ends.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : level_counter_if slave
//                inputs  clear, increment, decrement, load, load_value
//                outputs count (registered), at_max, at_min (decoded from
//                count), wrapped (registered one-cycle wrap pulse)
//   Parameters: WIDTH, MAX_LEVEL (1..2**WIDTH-1), WRAP (WRAP_MODE/SAT_MODE),
//               EDGE_MODE (EDGE_TRIGGER/LEVEL_TRIGGER).
module level_counter
  import maze_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_LEVEL = DEFAULT_MAX_LEVEL,
  parameter int WRAP      = WRAP_MODE,
  parameter int EDGE_MODE = EDGE_TRIGGER
) (
  input  logic            clk,
  input  logic            reset,
  level_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             step_up;
  logic             step_down;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_q;
  logic             wrapped_next;

  // Edge mode turns a held request into a single step; level mode steps
  // every cycle the request is high and needs no history.
  generate
    if (EDGE_MODE == EDGE_TRIGGER) begin : g_edge
      rise_detect u_inc_rise (
        .clk    (clk),
        .reset  (reset),
        .sig_in (bus.increment),
        .rise   (step_up)
      );
      rise_detect u_dec_rise (
        .clk    (clk),
        .reset  (reset),
        .sig_in (bus.decrement),
        .rise   (step_down)
      );
    end else begin : g_level
      assign step_up   = bus.increment;
      assign step_down = bus.decrement;
    end
  endgenerate

  // Next-state: clear beats load beats stepping. Simultaneous up and down
  // cancel. Increments only happen below MAX_VAL and decrements only above
  // zero, so the WIDTH-bit arithmetic never overflows.
  always_comb begin
    count_next   = count_q;
    wrapped_next = 1'b0;
    if (bus.clear) begin
      count_next = '0;
    end else if (bus.load) begin
      count_next = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;
    end else if (step_up && !step_down) begin
      if (count_q >= MAX_VAL) begin
        if (WRAP == WRAP_MODE) begin
          count_next   = '0;
          wrapped_next = 1'b1;
        end
      end else begin
        count_next = count_q + ONE;
      end
    end else if (step_down && !step_up) begin
      if (count_q == '0) begin
        if (WRAP == WRAP_MODE) begin
          count_next   = MAX_VAL;
          wrapped_next = 1'b1;
        end
      end else begin
        count_next = count_q - ONE;
      end
    end
  end

  // Level and wrap-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_next;
      wrapped_q <= wrapped_next;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrapped = wrapped_q;
  assign bus.at_max  = (count_q == MAX_VAL);
  assign bus.at_min  = (count_q == '0);

endmodule

// File: tb/tb_level_counter.sv
// tb_level_counter
//   Directed bench for level_counter. Four instances cover the parameter
//   corners: A default (wrap, max 7, edge), B saturating, C max 4,
//   D level-triggered saturating. All share clk and reset.
module tb_level_counter;

  logic clk;
  logic reset;

  int checkCount;
  int passCount;

  level_counter_if #(.WIDTH(3)) if_a ();
  level_counter_if #(.WIDTH(3)) if_b ();
  level_counter_if #(.WIDTH(3)) if_c ();
  level_counter_if #(.WIDTH(3)) if_d ();

  level_counter #(.WIDTH(3), .MAX_LEVEL(7), .WRAP(1), .EDGE_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  level_counter #(.WIDTH(3), .MAX_LEVEL(7), .WRAP(0), .EDGE_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );
  level_counter #(.WIDTH(3), .MAX_LEVEL(4), .WRAP(1), .EDGE_MODE(1)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c)
  );
  level_counter #(.WIDTH(3), .MAX_LEVEL(7), .WRAP(0), .EDGE_MODE(0)) dut_d (
    .clk(clk), .reset(reset), .bus(if_d)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    if_a.clear = 1'b0; if_a.increment = 1'b0; if_a.decrement = 1'b0; if_a.load = 1'b0; if_a.load_value = 3'd0;
    if_b.clear = 1'b0; if_b.increment = 1'b0; if_b.decrement = 1'b0; if_b.load = 1'b0; if_b.load_value = 3'd0;
    if_c.clear = 1'b0; if_c.increment = 1'b0; if_c.decrement = 1'b0; if_c.load = 1'b0; if_c.load_value = 3'd0;
    if_d.clear = 1'b0; if_d.increment = 1'b0; if_d.decrement = 1'b0; if_d.load = 1'b0; if_d.load_value = 3'd0;

    // Reset with increment already held high on A.
    if_a.increment = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_count",   int'(if_a.count),   0);
    checkOutput("reset_at_min",  int'(if_a.at_min),  1);
    checkOutput("reset_at_max",  int'(if_a.at_max),  0);
    checkOutput("reset_wrapped", int'(if_a.wrapped), 0);
    checkOutput("reset_count_c", int'(if_c.count),   0);

    // Held increment after reset release: exactly one step.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("held_inc_%0d", i), int'(if_a.count), 1);
    end
    if_a.increment = 1'b0;
    if_a.clear     = 1'b1;
    applyStimulus();
    if_a.clear = 1'b0;
    checkOutput("clear_count", int'(if_a.count), 0);

    // Eight single-cycle pulses: 1..7 then wrap to 0.
    for (int k = 1; k <= 8; k++) begin
      if_a.increment = 1'b1;
      applyStimulus();
      checkOutput($sformatf("pulse_%0d_count", k),   int'(if_a.count),   k % 8);
      checkOutput($sformatf("pulse_%0d_wrapped", k), int'(if_a.wrapped), (k == 8) ? 1 : 0);
      if_a.increment = 1'b0;
      applyStimulus();
      checkOutput($sformatf("pulse_%0d_idle_wrapped", k), int'(if_a.wrapped), 0);
    end

    // Wrap downward from 0 to 7.
    if_a.decrement = 1'b1;
    applyStimulus();
    checkOutput("down_wrap_count",   int'(if_a.count),   7);
    checkOutput("down_wrap_wrapped", int'(if_a.wrapped), 1);
    checkOutput("down_wrap_at_max",  int'(if_a.at_max),  1);
    if_a.decrement = 1'b0;
    applyStimulus();
    checkOutput("down_wrap_idle", int'(if_a.wrapped), 0);

    // Saturating instance at both ends.
    if_b.load       = 1'b1;
    if_b.load_value = 3'd7;
    applyStimulus();
    if_b.load = 1'b0;
    checkOutput("sat_load7", int'(if_b.count), 7);
    if_b.increment = 1'b1;
    applyStimulus();
    checkOutput("sat_top_count",   int'(if_b.count),   7);
    checkOutput("sat_top_wrapped", int'(if_b.wrapped), 0);
    checkOutput("sat_top_at_max",  int'(if_b.at_max),  1);
    if_b.increment = 1'b0;
    if_b.clear     = 1'b1;
    applyStimulus();
    if_b.clear     = 1'b0;
    if_b.decrement = 1'b1;
    applyStimulus();
    checkOutput("sat_bot_count",   int'(if_b.count),   0);
    checkOutput("sat_bot_wrapped", int'(if_b.wrapped), 0);
    checkOutput("sat_bot_at_min",  int'(if_b.at_min),  1);
    if_b.decrement = 1'b0;

    // Load above MAX_LEVEL clamps and swallows a rising increment.
    if_c.load       = 1'b1;
    if_c.load_value = 3'd6;
    if_c.increment  = 1'b1;
    applyStimulus();
    checkOutput("clamp_count",   int'(if_c.count),   4);
    checkOutput("clamp_wrapped", int'(if_c.wrapped), 0);
    checkOutput("clamp_at_max",  int'(if_c.at_max),  1);
    if_c.load = 1'b0;
    applyStimulus();
    checkOutput("clamp_no_late_step", int'(if_c.count), 4);
    if_c.increment = 1'b0;
    applyStimulus();
    if_c.increment = 1'b1;
    applyStimulus();
    checkOutput("max4_wrap_count",   int'(if_c.count),   0);
    checkOutput("max4_wrap_wrapped", int'(if_c.wrapped), 1);
    if_c.increment = 1'b0;

    // Level-triggered: up three cycles, then down four with floor at 0.
    if_d.increment = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("level_up_%0d", i), int'(if_d.count), i);
    end
    if_d.increment = 1'b0;
    if_d.decrement = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("level_down_%0d", i), int'(if_d.count), (i < 3) ? 3 - i : 0);
    end
    if_d.decrement = 1'b0;

    // Clear beats load; simultaneous up/down cancels; plain decrement.
    if_a.load       = 1'b1;
    if_a.load_value = 3'd3;
    applyStimulus();
    checkOutput("load3_count", int'(if_a.count), 3);
    if_a.clear      = 1'b1;
    if_a.load_value = 3'd5;
    applyStimulus();
    checkOutput("clear_over_load", int'(if_a.count), 0);
    if_a.clear     = 1'b0;
    if_a.load      = 1'b0;
    if_a.increment = 1'b1;
    if_a.decrement = 1'b1;
    applyStimulus();
    checkOutput("both_steps_count",   int'(if_a.count),   0);
    checkOutput("both_steps_wrapped", int'(if_a.wrapped), 0);
    if_a.increment  = 1'b0;
    if_a.decrement  = 1'b0;
    if_a.load       = 1'b1;
    if_a.load_value = 3'd3;
    applyStimulus();
    if_a.load      = 1'b0;
    if_a.decrement = 1'b1;
    applyStimulus();
    checkOutput("dec_from3", int'(if_a.count), 2);
    if_a.decrement = 1'b0;

    // Reset mid-operation at count 5 with increment rising.
    if_a.load       = 1'b1;
    if_a.load_value = 3'd5;
    applyStimulus();
    if_a.load = 1'b0;
    checkOutput("pre_reset_count", int'(if_a.count), 5);
    if_a.increment = 1'b1;
    reset          = 1'b1;
    applyStimulus();
    checkOutput("midreset_count",  int'(if_a.count),  0);
    checkOutput("midreset_at_min", int'(if_a.at_min), 1);
    reset = 1'b0;
    applyStimulus();
    checkOutput("post_reset_step", int'(if_a.count), 1);
    if_a.increment = 1'b0;
    applyStimulus();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
